// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the program counter and fetches one word at a time from instruction
// memory over a req/gnt/rvalid handshake. Each returned word is registered,
// together with the PC+4 of its fetch address, into the IF/ID register that
// feeds decode. A one-entry skid buffer sits behind the IF/ID register.
// Decode back-pressure (stall) and EX redirects (flush) are both honoured.
//
// Handshake semantics (imem side):
//   - A request is accepted in the cycle where o_imem_req and i_imem_gnt are
//     both 1. While the request is waiting for gnt, o_imem_req/o_imem_addr
//     stay stable and only drop through stall, redirect or a full skid buffer.
//   - At most one request is ever outstanding. Its single i_imem_rvalid pulse
//     arrives at least one cycle after the accepting cycle.
//
// Ports:
//   clk                   in   pipeline clock, rising edge
//   rst                   in   asynchronous, active-high reset
//   o_imem_req            out  fetch request valid
//   o_imem_addr           out  word-aligned fetch address (= PC)
//   i_imem_gnt            in   request accepted this cycle (with o_imem_req)
//   i_imem_rvalid         in   fetched word valid
//   i_imem_rdata          in   fetched instruction word
//   i_ID_stall            in   decode cannot accept; hold IF/ID
//   i_EX_ctrl_Redirect    in   taken branch/jump; flush and refetch
//   i_EX_data_RedirectPC  in   redirect target (bits [1:0] ignored)
//   o_ID_valid            out  IF/ID holds a valid instruction
//   o_ID_data_instruction out  instruction for decode
//   o_EX_data_PCNext      out  PC+4 of that instruction
// -----------------------------------------------------------------------------
module if_stage #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_ID_stall,
  input  logic              i_EX_ctrl_Redirect,
  input  logic [ADDR_W-1:0] i_EX_data_RedirectPC,
  output logic              o_ID_valid,
  output logic [31:0]       o_ID_data_instruction,
  output logic [ADDR_W-1:0] o_EX_data_PCNext
);

  // FETCH : allowed to request; PC is the address of the next fetch.
  // WAIT  : one request accepted, waiting for its rvalid.
  // DROP  : a request was outstanding when a redirect hit; swallow its rvalid.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // Sequential state
  logic [1:0]        state_q,       state_d;
  logic [ADDR_W-1:0] pc_q,          pc_d;
  logic [ADDR_W-1:0] pend_q,        pend_d;        // PC+4 of the outstanding fetch
  logic              id_valid_q,    id_valid_d;
  logic [31:0]       id_instr_q,    id_instr_d;
  logic [ADDR_W-1:0] id_pcnext_q,   id_pcnext_d;
  logic              skid_valid_q,  skid_valid_d;
  logic [31:0]       skid_instr_q,  skid_instr_d;
  logic [ADDR_W-1:0] skid_pcnext_q, skid_pcnext_d;

  // Combinational helpers
  logic              fetch_req;
  logic              fetch_fire;
  logic              resp_take;
  logic              resp_to_id;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_pc;
  logic              unused_redirect_lsbs;

  // Additions wrap naturally modulo 2^ADDR_W.
  assign pc_plus4    = pc_q + PC_STEP;
  assign redirect_pc = {i_EX_data_RedirectPC[ADDR_W-1:2], 2'b00};

  // Low target bits are architecturally ignored.
  assign unused_redirect_lsbs = ^i_EX_data_RedirectPC[1:0];

  // Request gating: a full skid buffer, or a valid-but-stalled IF/ID register,
  // means there would be nowhere to put the response, so no new fetch starts.
  // A redirect suppresses the request so the first fetch goes to the target.
  assign fetch_req = (state_q == ST_FETCH) && !skid_valid_q
                     && !(id_valid_q && i_ID_stall) && !i_EX_ctrl_Redirect
                     && !rst;
  assign fetch_fire = fetch_req && i_imem_gnt;

  // A response is kept only in WAIT and only if no redirect arrives with it.
  assign resp_take  = (state_q == ST_WAIT) && i_imem_rvalid && !i_EX_ctrl_Redirect;
  assign resp_to_id = resp_take && (!id_valid_q || !i_ID_stall);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pcnext_d   = id_pcnext_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pcnext_d = skid_pcnext_q;

    if (i_EX_ctrl_Redirect) begin
      // Redirect beats stall and every other event.
      pc_d         = redirect_pc;
      id_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      case (state_q)
        // An outstanding fetch must still return; if it has not yet, park in
        // DROP so its rvalid is discarded rather than taken as target data.
        ST_WAIT, ST_DROP: state_d = i_imem_rvalid ? ST_FETCH : ST_DROP;
        default:          state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (fetch_fire) begin
            pc_d    = pc_plus4;
            pend_d  = pc_plus4;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_imem_rvalid) state_d = ST_FETCH;
        end
        ST_DROP: begin
          if (i_imem_rvalid) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase

      // IF/ID register update
      if (resp_to_id) begin
        id_valid_d  = 1'b1;
        id_instr_d  = i_imem_rdata;
        id_pcnext_d = pend_q;
      end else if (!i_ID_stall) begin
        if (skid_valid_q) begin
          id_valid_d   = 1'b1;
          id_instr_d   = skid_instr_q;
          id_pcnext_d  = skid_pcnext_q;
          skid_valid_d = 1'b0;
        end else begin
          // Decode consumed the entry and nothing new arrived: bubble.
          id_valid_d = 1'b0;
        end
      end

      // Response arrived while IF/ID is full and stalled: park it.
      if (resp_take && !resp_to_id) begin
        skid_valid_d  = 1'b1;
        skid_instr_d  = i_imem_rdata;
        skid_pcnext_d = pend_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      pend_q        <= '0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pcnext_q   <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pcnext_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pcnext_q   <= id_pcnext_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pcnext_q <= skid_pcnext_d;
    end
  end

  assign o_imem_req            = fetch_req;
  assign o_imem_addr           = {pc_q[ADDR_W-1:2], 2'b00};
  assign o_ID_valid            = id_valid_q;
  assign o_ID_data_instruction = id_instr_q;
  assign o_EX_data_PCNext      = id_pcnext_q;

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
module tb_if_stage;

  localparam logic [31:0] XOR_KEY   = 32'hA5A5_0000;
  localparam logic [31:0] IDLE_DATA = 32'hDEAD_BEEF;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT wiring
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pcnext;

  if_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .o_imem_req            (imem_req),
    .o_imem_addr           (imem_addr),
    .i_imem_gnt            (imem_gnt),
    .i_imem_rvalid         (imem_rvalid),
    .i_imem_rdata          (imem_rdata),
    .i_ID_stall            (id_stall),
    .i_EX_ctrl_Redirect    (ex_redirect),
    .i_EX_data_RedirectPC  (ex_redirect_pc),
    .o_ID_valid            (id_valid),
    .o_ID_data_instruction (id_instr),
    .o_EX_data_PCNext      (id_pcnext)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;
  int          mem_lat  = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory content rule: word at addr is addr ^ XOR_KEY; PCNext is addr+4.
  function automatic logic [63:0] exp_entry(input logic [31:0] addr);
    return {addr ^ XOR_KEY, addr + 32'd4};
  endfunction

  // One clock cycle. Called just after a negedge with the test inputs set.
  task automatic step();
    logic        acc;
    logic [31:0] acc_addr;
    #1;
    if (!rst) begin
      check("single_outstanding", {63'd0, imem_req & mem_busy}, 64'd0);
      if (id_valid && !id_stall && !ex_redirect) begin
        if (exp_q.size() == 0) check("id_unexpected", {id_instr, id_pcnext}, 64'd0);
        else                   check("id_out", {id_instr, id_pcnext}, exp_q.pop_front());
      end
    end
    acc      = imem_req & imem_gnt;
    acc_addr = imem_addr;
    @(posedge clk);
    if (imem_rvalid) mem_busy = 1'b0;
    if (acc && !rst) begin
      mem_busy = 1'b1;
      mem_addr = acc_addr;
      mem_cnt  = mem_lat;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = IDLE_DATA;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ XOR_KEY;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    #1;
    while (!imem_req && n < budget) begin
      step();
      #1;
      n++;
    end
    check({tag, "_req"}, {63'd0, imem_req}, 64'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = IDLE_DATA;
    id_stall       = 1'b0;
    ex_redirect    = 1'b0;
    ex_redirect_pc = '0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_req",    {63'd0, imem_req}, 64'd0);
    check("rst_valid",  {63'd0, id_valid}, 64'd0);
    check("rst_instr",  64'(id_instr),     64'd0);
    check("rst_pcnext", 64'(id_pcnext),    64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Straight-line fetch, gnt always 1, 1-cycle latency
    imem_gnt = 1'b1;
    mem_lat  = 1;
    exp_q.push_back(exp_entry(32'h0));
    exp_q.push_back(exp_entry(32'h4));
    exp_q.push_back(exp_entry(32'h8));
    n = 0;
    while (!(id_valid && id_pcnext == 32'd12) && n < 40) begin
      step();
      n++;
    end
    check("stall_setup_valid", {63'd0, id_valid}, 64'd1);

    // Stall for 5 cycles with instr@0x8 in IF/ID
    id_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_no_req", {63'd0, imem_req}, 64'd0);
      check("stall_hold_valid", {63'd0, id_valid}, 64'd1);
      check("stall_hold_data", {id_instr, id_pcnext}, exp_entry(32'h8));
      step();
    end
    id_stall = 1'b0;
    mem_lat  = 3;
    exp_q.push_back(exp_entry(32'hC));
    #1;
    check("release_req",  {63'd0, imem_req}, 64'd1);
    check("release_addr", 64'(imem_addr), 64'hC);
    run_until_empty("stall", 60);

    // Redirect while the 0x10 fetch is outstanding (no rvalid this cycle)
    ex_redirect    = 1'b1;
    ex_redirect_pc = 32'h0000_0043;
    #1;
    check("redir_no_req", {63'd0, imem_req}, 64'd0);
    step();
    ex_redirect = 1'b0;
    #1;
    check("redir_flush_valid", {63'd0, id_valid}, 64'd0);
    mem_lat = 1;
    exp_q.push_back(exp_entry(32'h40));
    wait_req("redir_wait", 20);
    check("redir_target_addr", 64'(imem_addr), 64'h40);
    run_until_empty("redir_wait", 40);

    // Redirect together with stall while IF/ID holds a valid instruction
    id_stall = 1'b1;
    step();
    #1;
    check("flush_setup_valid", {63'd0, id_valid}, 64'd1);
    check("flush_setup_no_req", {63'd0, imem_req}, 64'd0);
    ex_redirect    = 1'b1;
    ex_redirect_pc = 32'h0000_0081;
    step();
    ex_redirect = 1'b0;
    #1;
    check("flush_stall_valid", {63'd0, id_valid}, 64'd0);
    id_stall = 1'b0;
    exp_q.push_back(exp_entry(32'h80));
    wait_req("flush_stall", 20);
    check("flush_target_addr", 64'(imem_addr), 64'h80);
    run_until_empty("flush_stall", 40);

    // Redirect to the top word, gnt withheld for 3 cycles, then wrap
    ex_redirect    = 1'b1;
    ex_redirect_pc = 32'hFFFF_FFFC;
    imem_gnt       = 1'b0;
    step();
    ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wrap_hold_req",  {63'd0, imem_req}, 64'd1);
      check("wrap_hold_addr", 64'(imem_addr), 64'hFFFF_FFFC);
      step();
    end
    imem_gnt = 1'b1;
    mem_lat  = 4;
    exp_q.push_back(exp_entry(32'hFFFF_FFFC));
    exp_q.push_back(exp_entry(32'h0));
    run_until_empty("wrap", 60);

    // Reset asserted while a fetch is outstanding (WAIT)
    rst = 1'b1;
    #1;
    check("midrst_req",    {63'd0, imem_req}, 64'd0);
    check("midrst_valid",  {63'd0, id_valid}, 64'd0);
    check("midrst_instr",  64'(id_instr),     64'd0);
    check("midrst_pcnext", 64'(id_pcnext),    64'd0);
    mem_busy    = 1'b0;
    imem_rvalid = 1'b0;
    @(negedge clk);
    rst         = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;              // stale response from before the reset
    imem_rdata  = 32'h0000_0004 ^ XOR_KEY;
    #1;
    check("postrst_req",  {63'd0, imem_req}, 64'd1);
    check("postrst_addr", 64'(imem_addr), 64'h0);
    step();
    imem_gnt = 1'b1;
    exp_q.push_back(exp_entry(32'h0));
    run_until_empty("postrst", 40);

    // Random gnt, latency and stall over straight-line code
    for (int i = 1; i <= 8; i++) exp_q.push_back(exp_entry(32'(4 * i)));
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      imem_gnt = 1'($urandom_range(0, 1));
      id_stall = ($urandom_range(0, 3) == 0);
      mem_lat  = $urandom_range(1, 3);
      step();
      n++;
    end
    id_stall = 1'b0;
    imem_gnt = 1'b1;
    check("random_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
